// File: rtl/noc_intr_pkt_deframer.sv
// Off-chip interrupt flit deframer: parses NoC headers, delivers single-payload
// interrupt packets as one registered record, and drains/counts everything else.

`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 64
`endif
`ifndef NOC_X_WIDTH
`define NOC_X_WIDTH 8
`endif
`ifndef NOC_Y_WIDTH
`define NOC_Y_WIDTH 8
`endif
`ifndef MSG_DST_X
`define MSG_DST_X 49:42
`endif
`ifndef MSG_DST_Y
`define MSG_DST_Y 41:34
`endif
`ifndef MSG_LENGTH
`define MSG_LENGTH 29:22
`endif
`ifndef MSG_TYPE
`define MSG_TYPE 21:14
`endif
`ifndef MSG_TYPE_INTERRUPT
`define MSG_TYPE_INTERRUPT 8'd60
`endif

module noc_intr_pkt_deframer #(
  parameter logic [7:0] INTR_MSG_TYPE = `MSG_TYPE_INTERRUPT,
  parameter int         CNT_WIDTH     = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       noc_in_val,
  output logic                       noc_in_rdy,
  input  logic [`NOC_DATA_WIDTH-1:0] noc_in_data,
  output logic                       intr_val,
  input  logic                       intr_rdy,
  output logic [`NOC_X_WIDTH-1:0]    intr_x,
  output logic [`NOC_Y_WIDTH-1:0]    intr_y,
  output logic [63:0]                intr_payload,
  output logic [CNT_WIDTH-1:0]       pkt_count,
  output logic [CNT_WIDTH-1:0]       drop_count
);

  typedef enum logic [1:0] {HDR, BODY, DRAIN} state_t;

  state_t                     state_q, state_d;
  logic [7:0]                 remaining_q, remaining_d;
  logic [`NOC_X_WIDTH-1:0]    hdr_x_q, hdr_x_d;
  logic [`NOC_Y_WIDTH-1:0]    hdr_y_q, hdr_y_d;
  logic                       intr_val_q, intr_val_d;
  logic [`NOC_X_WIDTH-1:0]    intr_x_q, intr_x_d;
  logic [`NOC_Y_WIDTH-1:0]    intr_y_q, intr_y_d;
  logic [63:0]                payload_q, payload_d;
  logic [CNT_WIDTH-1:0]       pkt_q, pkt_d;
  logic [CNT_WIDTH-1:0]       drop_q, drop_d;

  logic       in_rdy;
  logic       xfer;
  logic [7:0] hdr_len;
  logic [7:0] hdr_type;

  assign hdr_len  = noc_in_data[`MSG_LENGTH];
  assign hdr_type = noc_in_data[`MSG_TYPE];

  // Ready depends only on state and the output slot, never on noc_in_val.
  always_comb begin
    in_rdy = 1'b1;
    if (state_q == BODY) in_rdy = !intr_val_q || intr_rdy;
  end

  assign xfer = noc_in_val && in_rdy;

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    hdr_x_d     = hdr_x_q;
    hdr_y_d     = hdr_y_q;
    intr_val_d  = intr_val_q;
    intr_x_d    = intr_x_q;
    intr_y_d    = intr_y_q;
    payload_d   = payload_q;
    pkt_d       = pkt_q;
    drop_d      = drop_q;

    if (intr_val_q && intr_rdy) intr_val_d = 1'b0;

    // Data fields are only looked at under xfer, so idle data never reaches state.
    unique case (state_q)
      HDR: begin
        if (xfer) begin
          if (hdr_type == INTR_MSG_TYPE && hdr_len == 8'd1) begin
            hdr_x_d = noc_in_data[`MSG_DST_X];
            hdr_y_d = noc_in_data[`MSG_DST_Y];
            state_d = BODY;
          end else begin
            if (drop_q != {CNT_WIDTH{1'b1}}) drop_d = drop_q + 1'b1;
            if (hdr_len != 8'd0) begin
              remaining_d = hdr_len;
              state_d     = DRAIN;
            end
          end
        end
      end
      BODY: begin
        if (xfer) begin
          intr_val_d = 1'b1;
          intr_x_d   = hdr_x_q;
          intr_y_d   = hdr_y_q;
          payload_d  = noc_in_data;
          if (pkt_q != {CNT_WIDTH{1'b1}}) pkt_d = pkt_q + 1'b1;
          state_d    = HDR;
        end
      end
      DRAIN: begin
        if (xfer) begin
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) state_d = HDR;
        end
      end
      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= HDR;
      remaining_q <= '0;
      hdr_x_q     <= '0;
      hdr_y_q     <= '0;
      intr_val_q  <= 1'b0;
      intr_x_q    <= '0;
      intr_y_q    <= '0;
      payload_q   <= '0;
      pkt_q       <= '0;
      drop_q      <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      hdr_x_q     <= hdr_x_d;
      hdr_y_q     <= hdr_y_d;
      intr_val_q  <= intr_val_d;
      intr_x_q    <= intr_x_d;
      intr_y_q    <= intr_y_d;
      payload_q   <= payload_d;
      pkt_q       <= pkt_d;
      drop_q      <= drop_d;
    end
  end

  assign noc_in_rdy   = in_rdy;
  assign intr_val     = intr_val_q;
  assign intr_x       = intr_x_q;
  assign intr_y       = intr_y_q;
  assign intr_payload = payload_q;
  assign pkt_count    = pkt_q;
  assign drop_count   = drop_q;

endmodule

// File: tb/tb_noc_intr_pkt_deframer.sv
// Directed bench for noc_intr_pkt_deframer: one task per scenario, inline checks,
// narrow counters so saturation is reachable quickly.

module tb_noc_intr_pkt_deframer;

  localparam logic [7:0] T   = 8'd60;
  localparam logic [7:0] NT  = 8'h11;
  localparam int         CW  = 4;
  localparam logic [63:0] IDLE = 64'hDEAD_BEEF_DEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          noc_in_val;
  logic          noc_in_rdy;
  logic [63:0]   noc_in_data;
  logic          intr_val;
  logic          intr_rdy;
  logic [7:0]    intr_x;
  logic [7:0]    intr_y;
  logic [63:0]   intr_payload;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] drop_count;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  noc_intr_pkt_deframer #(.INTR_MSG_TYPE(T), .CNT_WIDTH(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .noc_in_val   (noc_in_val),
    .noc_in_rdy   (noc_in_rdy),
    .noc_in_data  (noc_in_data),
    .intr_val     (intr_val),
    .intr_rdy     (intr_rdy),
    .intr_x       (intr_x),
    .intr_y       (intr_y),
    .intr_payload (intr_payload),
    .pkt_count    (pkt_count),
    .drop_count   (drop_count)
  );

  function automatic logic [63:0] hdr(input logic [7:0] x, input logic [7:0] y,
                                      input logic [7:0] len, input logic [7:0] typ);
    logic [63:0] h;
    h        = '0;
    h[63:50] = 14'h2A5;
    h[49:42] = x;
    h[41:34] = y;
    h[29:22] = len;
    h[21:14] = typ;
    h[13:0]  = 14'h1234;
    return h;
  endfunction

  // Advance one clock; sample point is 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [63:0] d);
    noc_in_val  = v;
    noc_in_data = d;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    intr_rdy = 1'b1;
    drive(1'b0, IDLE);
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (intr_val !== 1'b0) begin failures++; $display("FAIL reset_val got=%0h exp=0", intr_val); end
    checks++; if ({intr_x, intr_y, intr_payload} !== 80'h0) begin failures++; $display("FAIL reset_rec got=%0h/%0h/%0h exp=0/0/0", intr_x, intr_y, intr_payload); end
    checks++; if (pkt_count !== 4'h0 || drop_count !== 4'h0) begin failures++; $display("FAIL reset_cnt got=%0h/%0h exp=0/0", pkt_count, drop_count); end
    checks++; if (noc_in_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%0h exp=1", noc_in_rdy); end
    $display("test_reset done");
  endtask

  task automatic test_back_to_back();
    int rdy_low;
    do_reset();
    rdy_low = 0;
    drive(1'b1, hdr(8'd1, 8'd1, 8'd1, T)); if (!noc_in_rdy) rdy_low++; tick();
    drive(1'b1, 64'h0000_0000_0001_0001);  if (!noc_in_rdy) rdy_low++; tick();
    checks++; if ({intr_val, intr_x, intr_y, intr_payload} !== {1'b1, 8'd1, 8'd1, 64'h10001})
      begin failures++; $display("FAIL b2b_rec1 got=%0h/%0h/%0h/%0h exp=1/1/1/10001", intr_val, intr_x, intr_y, intr_payload); end
    checks++; if (pkt_count !== 4'd1) begin failures++; $display("FAIL b2b_pkt1 got=%0d exp=1", pkt_count); end
    drive(1'b1, hdr(8'd0, 8'd0, 8'd1, T)); if (!noc_in_rdy) rdy_low++; tick();
    checks++; if (intr_val !== 1'b0) begin failures++; $display("FAIL b2b_consumed got=%0h exp=0", intr_val); end
    drive(1'b1, 64'h5); if (!noc_in_rdy) rdy_low++; tick();
    checks++; if ({intr_val, intr_x, intr_y, intr_payload} !== {1'b1, 8'd0, 8'd0, 64'h5})
      begin failures++; $display("FAIL b2b_rec2 got=%0h/%0h/%0h/%0h exp=1/0/0/5", intr_val, intr_x, intr_y, intr_payload); end
    checks++; if (pkt_count !== 4'd2 || drop_count !== 4'd0) begin failures++; $display("FAIL b2b_cnt got=%0d/%0d exp=2/0", pkt_count, drop_count); end
    checks++; if (rdy_low !== 0) begin failures++; $display("FAIL b2b_rdy_low got=%0d exp=0", rdy_low); end
    drive(1'b0, IDLE); tick();
    checks++; if (intr_val !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%0h exp=0", intr_val); end
    $display("test_back_to_back done");
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, hdr(8'd2, 8'd3, 8'd1, T)); tick();
    drive(1'b1, 64'hAAAA); intr_rdy = 1'b0; tick();
    checks++; if ({intr_val, intr_payload} !== {1'b1, 64'hAAAA}) begin failures++; $display("FAIL bp_rec1 got=%0h/%0h exp=1/aaaa", intr_val, intr_payload); end
    drive(1'b1, hdr(8'd4, 8'd5, 8'd1, T));
    checks++; if (noc_in_rdy !== 1'b1) begin failures++; $display("FAIL bp_hdr_rdy got=%0h exp=1", noc_in_rdy); end
    tick();
    drive(1'b1, 64'hBBBB);
    checks++; if (noc_in_rdy !== 1'b0) begin failures++; $display("FAIL bp_pay_rdy got=%0h exp=0", noc_in_rdy); end
    tick(); tick();
    checks++; if ({intr_val, intr_x, intr_y, intr_payload} !== {1'b1, 8'd2, 8'd3, 64'hAAAA})
      begin failures++; $display("FAIL bp_hold got=%0h/%0h/%0h/%0h exp=1/2/3/aaaa", intr_val, intr_x, intr_y, intr_payload); end
    checks++; if (pkt_count !== 4'd1) begin failures++; $display("FAIL bp_pkt_hold got=%0d exp=1", pkt_count); end
    intr_rdy = 1'b1; #1;
    checks++; if (noc_in_rdy !== 1'b1) begin failures++; $display("FAIL bp_rdy_release got=%0h exp=1", noc_in_rdy); end
    tick();
    drive(1'b0, IDLE);
    checks++; if ({intr_val, intr_x, intr_y, intr_payload} !== {1'b1, 8'd4, 8'd5, 64'hBBBB})
      begin failures++; $display("FAIL bp_swap got=%0h/%0h/%0h/%0h exp=1/4/5/bbbb", intr_val, intr_x, intr_y, intr_payload); end
    checks++; if (pkt_count !== 4'd2) begin failures++; $display("FAIL bp_pkt got=%0d exp=2", pkt_count); end
    tick();
    checks++; if (intr_val !== 1'b0) begin failures++; $display("FAIL bp_drain_slot got=%0h exp=0", intr_val); end
    $display("test_backpressure done");
  endtask

  task automatic test_drain();
    int rdy_low;
    int val_seen;
    do_reset();
    rdy_low = 0; val_seen = 0;
    drive(1'b1, hdr(8'd1, 8'd2, 8'd3, NT)); tick();
    checks++; if (drop_count !== 4'd1) begin failures++; $display("FAIL drain_drop got=%0d exp=1", drop_count); end
    // The last drained flit looks like an interrupt header to catch a short drain.
    drive(1'b1, hdr(8'd9, 8'd9, 8'd1, T)); if (!noc_in_rdy) rdy_low++; tick(); if (intr_val) val_seen++;
    drive(1'b1, 64'h0);                   if (!noc_in_rdy) rdy_low++; tick(); if (intr_val) val_seen++;
    drive(1'b1, hdr(8'd9, 8'd9, 8'd1, T)); if (!noc_in_rdy) rdy_low++; tick(); if (intr_val) val_seen++;
    checks++; if (rdy_low !== 0 || val_seen !== 0) begin failures++; $display("FAIL drain_body got=%0d/%0d exp=0/0", rdy_low, val_seen); end
    drive(1'b1, hdr(8'd6, 8'd7, 8'd1, T)); tick();
    drive(1'b1, 64'h77); tick();
    drive(1'b0, IDLE);
    checks++; if ({intr_val, intr_x, intr_y, intr_payload} !== {1'b1, 8'd6, 8'd7, 64'h77})
      begin failures++; $display("FAIL drain_rec got=%0h/%0h/%0h/%0h exp=1/6/7/77", intr_val, intr_x, intr_y, intr_payload); end
    checks++; if (pkt_count !== 4'd1 || drop_count !== 4'd1) begin failures++; $display("FAIL drain_cnt got=%0d/%0d exp=1/1", pkt_count, drop_count); end
    tick();
    $display("test_drain done");
  endtask

  task automatic test_hdr_only();
    do_reset();
    drive(1'b1, hdr(8'd3, 8'd3, 8'd0, T)); tick();
    checks++; if (drop_count !== 4'd1 || intr_val !== 1'b0) begin failures++; $display("FAIL hdronly_drop got=%0d/%0h exp=1/0", drop_count, intr_val); end
    drive(1'b1, hdr(8'd5, 8'd6, 8'd1, T)); tick();
    checks++; if (intr_val !== 1'b0) begin failures++; $display("FAIL hdronly_noval got=%0h exp=0", intr_val); end
    drive(1'b1, 64'h99); tick();
    drive(1'b0, IDLE);
    checks++; if ({intr_val, intr_x, intr_y, intr_payload} !== {1'b1, 8'd5, 8'd6, 64'h99})
      begin failures++; $display("FAIL hdronly_rec got=%0h/%0h/%0h/%0h exp=1/5/6/99", intr_val, intr_x, intr_y, intr_payload); end
    checks++; if (pkt_count !== 4'd1) begin failures++; $display("FAIL hdronly_pkt got=%0d exp=1", pkt_count); end
    tick();
    $display("test_hdr_only done");
  endtask

  task automatic test_len2();
    int val_seen;
    do_reset();
    val_seen = 0;
    drive(1'b1, hdr(8'd1, 8'd1, 8'd2, T)); tick();
    drive(1'b1, hdr(8'd2, 8'd2, 8'd1, T)); tick(); if (intr_val) val_seen++;
    drive(1'b1, hdr(8'd8, 8'd8, 8'd1, T)); tick(); if (intr_val) val_seen++;
    checks++; if (val_seen !== 0 || pkt_count !== 4'd0 || drop_count !== 4'd1)
      begin failures++; $display("FAIL len2_drop got=%0d/%0d/%0d exp=0/0/1", val_seen, pkt_count, drop_count); end
    drive(1'b1, hdr(8'd7, 8'd7, 8'd1, T)); tick();
    drive(1'b1, 64'h42); tick();
    drive(1'b0, IDLE);
    checks++; if ({intr_val, intr_x, intr_y, intr_payload} !== {1'b1, 8'd7, 8'd7, 64'h42})
      begin failures++; $display("FAIL len2_next got=%0h/%0h/%0h/%0h exp=1/7/7/42", intr_val, intr_x, intr_y, intr_payload); end
    tick();
    $display("test_len2 done");
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(1'b1, hdr(8'd0, 8'd0, 8'd0, NT)); tick();
    end
    checks++; if (drop_count !== 4'hE) begin failures++; $display("FAIL sat_pre got=%0h exp=e", drop_count); end
    drive(1'b1, hdr(8'd0, 8'd0, 8'd0, NT)); tick();
    checks++; if (drop_count !== 4'hF) begin failures++; $display("FAIL sat_max got=%0h exp=f", drop_count); end
    drive(1'b1, hdr(8'd0, 8'd0, 8'd0, NT)); tick();
    drive(1'b0, IDLE);
    checks++; if (drop_count !== 4'hF) begin failures++; $display("FAIL sat_hold got=%0h exp=f", drop_count); end
    $display("test_saturation done");
  endtask

  task automatic test_reset_mid();
    // Reset while in BODY with a record pending.
    do_reset();
    drive(1'b1, hdr(8'd1, 8'd1, 8'd1, T)); tick();
    drive(1'b1, 64'hCC); intr_rdy = 1'b0; tick();
    drive(1'b1, hdr(8'd2, 8'd2, 8'd1, T)); tick();
    drive(1'b0, IDLE);
    rst_n = 1'b0; tick(); rst_n = 1'b1; intr_rdy = 1'b1;
    checks++; if ({intr_val, intr_x, intr_y, intr_payload} !== 81'h0)
      begin failures++; $display("FAIL rstbody_rec got=%0h/%0h/%0h/%0h exp=0/0/0/0", intr_val, intr_x, intr_y, intr_payload); end
    checks++; if (pkt_count !== 4'd0 || drop_count !== 4'd0 || noc_in_rdy !== 1'b1)
      begin failures++; $display("FAIL rstbody_cnt got=%0d/%0d/%0h exp=0/0/1", pkt_count, drop_count, noc_in_rdy); end
    drive(1'b1, hdr(8'd2, 8'd1, 8'd1, T)); tick();
    drive(1'b1, 64'h31); tick();
    drive(1'b0, IDLE);
    checks++; if ({intr_val, intr_x, intr_y, intr_payload} !== {1'b1, 8'd2, 8'd1, 64'h31})
      begin failures++; $display("FAIL rstbody_next got=%0h/%0h/%0h/%0h exp=1/2/1/31", intr_val, intr_x, intr_y, intr_payload); end
    tick();
    // Reset while in DRAIN.
    drive(1'b1, hdr(8'd0, 8'd0, 8'd5, NT)); tick();
    drive(1'b1, 64'h0); tick();
    drive(1'b0, IDLE);
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    checks++; if (drop_count !== 4'd0 || pkt_count !== 4'd0 || intr_val !== 1'b0)
      begin failures++; $display("FAIL rstdrain_cnt got=%0d/%0d/%0h exp=0/0/0", drop_count, pkt_count, intr_val); end
    drive(1'b1, hdr(8'd3, 8'd4, 8'd1, T)); tick();
    drive(1'b1, 64'h34); tick();
    drive(1'b0, IDLE);
    checks++; if ({intr_val, intr_x, intr_y, intr_payload} !== {1'b1, 8'd3, 8'd4, 64'h34})
      begin failures++; $display("FAIL rstdrain_next got=%0h/%0h/%0h/%0h exp=1/3/4/34", intr_val, intr_x, intr_y, intr_payload); end
    checks++; if (drop_count !== 4'd0 || pkt_count !== 4'd1)
      begin failures++; $display("FAIL rstdrain_after got=%0d/%0d exp=0/1", drop_count, pkt_count); end
    tick();
    $display("test_reset_mid done");
  endtask

  initial begin
    rst_n       = 1'b0;
    intr_rdy    = 1'b1;
    noc_in_val  = 1'b0;
    noc_in_data = IDLE;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_drain();
    test_hdr_only();
    test_len2();
    test_saturation();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_intr_pkt_deframer.md
# noc_intr_pkt_deframer

Chipset-side consumer of the off-chip interrupt flit stream produced by the fake IOB's async output buffer. It accepts 64-bit NoC flits on a val/rdy channel and parses the header. Well-formed single-payload interrupt packets are delivered as one decoded record (destination X/Y plus payload flit) on a registered val/rdy output. All other packets are drained and counted. It runs entirely in the off-chip `clk` domain, directly downstream of the IOB `noc_out_*` port.

## Interface
- `INTR_MSG_TYPE`, default `` `MSG_TYPE_INTERRUPT ``: message-type value that is accepted as an interrupt.
- `CNT_WIDTH`, default 16: width of the statistics counters.

- `clk`  in  1  off-chip clock; all state updates on posedge.
- `rst_n`  in  1  synchronous, active-low reset.
- `noc_in_val`  in  1  input flit valid.
- `noc_in_rdy`  out  1  input flit ready (combinational from state and output slot).
- `noc_in_data`  in  `` `NOC_DATA_WIDTH `` (64)  input flit.
- `intr_val`  out  1  decoded interrupt record valid.
- `intr_rdy`  in  1  consumer ready.
- `intr_x`  out  `` `NOC_X_WIDTH ``  destination X from header `` `MSG_DST_X `` [49:42].
- `intr_y`  out  `` `NOC_Y_WIDTH ``  destination Y from header `` `MSG_DST_Y `` [41:34].
- `intr_payload`  out  64  payload flit, unmodified.
- `pkt_count`  out  CNT_WIDTH  interrupt records delivered; saturating.
- `drop_count`  out  CNT_WIDTH  packets discarded; saturating.

## Operation
- Header fields: `` `MSG_LENGTH `` [29:22] gives the number of payload flits, 0–255. `` `MSG_TYPE `` [21:14]. X/Y at the positions given above.
- An input flit transfers on a cycle with `noc_in_val && noc_in_rdy`.
- States: HDR (reset), BODY, DRAIN.
- HDR: `noc_in_rdy`=1. On a header transfer:
  - type==INTR_MSG_TYPE and len==1: latch X/Y into header regs, go to BODY.
  - len==0, any type: header-only packet. drop_count+1, stay in HDR.
  - Otherwise: drop_count+1, load `remaining`=len (8 bits), go to DRAIN.
- BODY: `noc_in_rdy` = `!intr_val || intr_rdy`. On transfer: load the output regs (x, y, payload), set intr_val, pkt_count+1, go to HDR.
- DRAIN: `noc_in_rdy`=1. Each transfer decrements `remaining`. The transfer with `remaining`==1 returns to HDR. Payload content is ignored.
- Output slot: one entry, fully registered. `intr_val` clears on `intr_val && intr_rdy` unless it is reloaded in the same cycle. Simultaneous consume and load gives `intr_val` still 1 with the new record.
- Output regs hold their value while `intr_val`=1 and `intr_rdy`=0.
- Counters saturate at all-ones and never wrap. A drop and a delivery can never occur in the same cycle.
- Reset (`rst_n`=0 at posedge): state=HDR, remaining=0, header regs=0, `intr_val`=0, `intr_x`/`intr_y`/`intr_payload`=0, both counters=0.
- Reset mid-packet discards the partial packet and the pending record, and is not counted. The next flit after reset is treated as a header.
- `noc_in_data` is ignored when `noc_in_val`=0. No X-propagation from idle data into state.

## Timing
- Header → BODY: 1 cycle after the header transfer.
- Payload transfer at cycle N: `intr_val`=1 and the record visible at N+1, pkt_count updated at N+1.
- Throughput: one interrupt record per 2 flit-cycles sustained when `intr_rdy`=1, matching the 2-flit IOB packet.
- With `intr_rdy` held 0 and one record pending, the next interrupt header is still accepted. Its payload stalls in BODY with `noc_in_rdy`=0. There is no combinational path from `noc_in_val` to `noc_in_rdy`.
- drop_count updates the cycle after the dropping header transfer.
- DRAIN of a len=L packet takes exactly L transfer cycles.

## Test plan
- Back-to-back IOB packets: header {X=1,Y=1,len=1,type=INTR}, payload 0x0000_0000_0001_0001, then header {X=0,Y=0}, payload 0x5. Keep `intr_rdy`=1. Expect records (1,1,0x10001) and (0,0,0x5), each 1 cycle after its payload; pkt_count=2, drop_count=0, `noc_in_rdy` never 0.
- Backpressure: hold `intr_rdy`=0 after the first record, then send a second packet. Expect the header accepted, `noc_in_rdy`=0 on the payload, record 1 held stable. Raise `intr_rdy` for 1 cycle: record 1 consumed and record 2 loaded in the same cycle with `intr_val` staying 1.
- Non-interrupt type with len=3 followed by a valid interrupt packet. Expect 3 drained flits, drop_count=1, then one record with pkt_count=1.
- Header-only packet (type=INTR, len=0) immediately followed by a good packet. Expect drop_count=1, no `intr_val` for the first, the good record delivered normally.
- Interrupt type with len=2. Expect the packet dropped and drained over 2 cycles, no record.
- Saturation and reset: force drop_count to 0xFFFE via 2 more drops and expect 0xFFFF to hold. Assert `rst_n`=0 while in BODY and in DRAIN. Expect all outputs 0 and state HDR, with the next flit parsed as a header.
